// File: rtl/exc_pkg.sv
// Shared definitions for the exception sequencer: cause codes, FSM states and
// the interrupt-enable stack helpers.
package exc_pkg;

    localparam logic [3:0] CAUSE_INT = 4'd0;
    localparam logic [3:0] CAUSE_RI  = 4'd10;
    localparam logic [3:0] CAUSE_OV  = 4'd12;
    localparam logic [3:0] CAUSE_TR  = 4'd13;

    // Only the IE bits of {IEo,KUo,IEp,KUp,IEc,KUc} are writable.
    localparam logic [5:0] STATUS_WMASK = 6'b101010;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_e;

    function automatic logic [5:0] status_push(input logic [5:0] s);
        return {s[3:0], 2'b00};
    endfunction

    // Pop keeps IEo in place, so a pop after three pushes duplicates IEo.
    function automatic logic [5:0] status_pop(input logic [5:0] s);
        return {s[5:4], s[5:2]};
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder of the exception sources: interrupt, undefined
// instruction, overflow, trap.
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic       irq_en_i,
    input  logic       no_define_i,
    input  logic       ovf_i,
    input  logic       trap_sign_i,
    output logic       hit_o,
    output logic [3:0] code_o
);

    always_comb begin
        hit_o  = 1'b1;
        code_o = CAUSE_INT;
        if (irq_en_i) begin
            code_o = CAUSE_INT;
        end else if (no_define_i) begin
            code_o = CAUSE_RI;
        end else if (ovf_i) begin
            code_o = CAUSE_OV;
        end else if (trap_sign_i) begin
            code_o = CAUSE_TR;
        end else begin
            hit_o  = 1'b0;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception sequencer: records EPC/cause, maintains the IE stack and runs
// flush -> redirect for exception entry and rfe.
//
// state    | meaning
// IDLE     | evaluate events on valid instructions, accept status writes
// FLUSH    | flush and stall asserted for FLUSH_CYCLES cycles
// REDIRECT | one-cycle PC load with redirect_pc, stall held
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] VECTOR_ADDR  = PC_W'(32'h0000_0080),
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inst_valid,
    input  logic [PC_W-1:0] pc,
    input  logic            no_define,
    input  logic            trap_sign,
    input  logic            ovf,
    input  logic            rfe,
    input  logic            irq,
    input  logic            sr_we,
    input  logic [5:0]      sr_wdata,
    output logic [PC_W-1:0] epc,
    output logic [3:0]      cause,
    output logic [5:0]      status,
    output logic            stall,
    output logic            flush,
    output logic            pc_redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic            exc_taken
);

    localparam int                 CNT_W    = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PC_W-1:0]   epc_q, epc_d;
    logic [3:0]        cause_q, cause_d;
    logic [5:0]        status_q, status_d;
    logic [PC_W-1:0]   target_q, target_d;
    logic [PC_W-1:0]   rpc_q, rpc_d;
    logic              taken_q, taken_d;

    logic              hit;
    logic [3:0]        code;
    logic              exc_fire;
    logic              rfe_fire;

    exc_prio_enc u_prio (
        .irq_en_i    (irq & status_q[1]),
        .no_define_i (no_define),
        .ovf_i       (ovf),
        .trap_sign_i (trap_sign),
        .hit_o       (hit),
        .code_o      (code)
    );

    assign exc_fire = inst_valid & hit;
    assign rfe_fire = inst_valid & rfe;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        epc_d    = epc_q;
        cause_d  = cause_q;
        status_d = status_q;
        target_d = target_q;
        rpc_d    = rpc_q;
        taken_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (exc_fire) begin
                    epc_d    = pc;
                    cause_d  = code;
                    status_d = status_push(status_q);
                    taken_d  = 1'b1;
                    target_d = VECTOR_ADDR;
                    cnt_d    = CNT_INIT;
                    state_d  = FLUSH;
                end else if (rfe_fire) begin
                    status_d = status_pop(status_q);
                    target_d = epc_q;
                    cnt_d    = CNT_INIT;
                    state_d  = FLUSH;
                end else if (sr_we) begin
                    status_d = sr_wdata & STATUS_WMASK;
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    rpc_d   = target_q;
                    state_d = REDIRECT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            epc_q    <= '0;
            cause_q  <= '0;
            status_q <= '0;
            target_q <= '0;
            rpc_q    <= '0;
            taken_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            epc_q    <= epc_d;
            cause_q  <= cause_d;
            status_q <= status_d;
            target_q <= target_d;
            rpc_q    <= rpc_d;
            taken_q  <= taken_d;
        end
    end

    assign epc         = epc_q;
    assign cause       = cause_q;
    assign status      = status_q;
    assign stall       = (state_q != IDLE);
    assign flush       = (state_q == FLUSH);
    assign pc_redirect = (state_q == REDIRECT);
    assign redirect_pc = rpc_q;
    assign exc_taken   = taken_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: vector table, directed corner sequences
// and randomized traffic against a sequence-position reference model.
module tb_exc_ctrl;

    localparam int          PC_W = 32;
    localparam int          FC   = 2;
    localparam logic [31:0] VEC  = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid, no_define, trap_sign, ovf, rfe, irq, sr_we;
    logic [31:0] pc;
    logic [5:0]  sr_wdata;
    logic [31:0] epc, redirect_pc;
    logic [3:0]  cause;
    logic [5:0]  status;
    logic        stall, flush, pc_redirect, exc_taken;

    always #5 clk = ~clk;

    exc_ctrl #(.PC_W(PC_W), .VECTOR_ADDR(VEC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .pc(pc),
        .no_define(no_define), .trap_sign(trap_sign), .ovf(ovf), .rfe(rfe),
        .irq(irq), .sr_we(sr_we), .sr_wdata(sr_wdata), .epc(epc),
        .cause(cause), .status(status), .stall(stall), .flush(flush),
        .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
        .exc_taken(exc_taken)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pos 0 = idle, 1..FC = flushing, FC+1 = redirect.
    int          pos;
    logic [31:0] m_epc, m_target, m_rpc;
    logic [3:0]  m_cause;
    logic        ie_c, ie_p, ie_o, m_taken;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pos = 0; m_epc = '0; m_target = '0; m_rpc = '0; m_cause = '0;
        ie_c = 1'b0; ie_p = 1'b0; ie_o = 1'b0; m_taken = 1'b0;
    endtask

    task automatic model_step();
        int code;
        bit fire;
        code = 0;
        fire = 1'b0;
        m_taken = 1'b0;
        if (pos == 0) begin
            if (inst_valid) begin
                if (irq && ie_c)    begin fire = 1'b1; code = 0;  end
                else if (no_define) begin fire = 1'b1; code = 10; end
                else if (ovf)       begin fire = 1'b1; code = 12; end
                else if (trap_sign) begin fire = 1'b1; code = 13; end
            end
            if (fire) begin
                m_epc = pc; m_cause = code[3:0];
                ie_o = ie_p; ie_p = ie_c; ie_c = 1'b0;
                m_taken = 1'b1; m_target = VEC; pos = 1;
            end else if (inst_valid && rfe) begin
                ie_c = ie_p; ie_p = ie_o;
                m_target = m_epc; pos = 1;
            end else if (sr_we) begin
                ie_c = sr_wdata[1]; ie_p = sr_wdata[3]; ie_o = sr_wdata[5];
            end
        end else if (pos <= FC) begin
            pos++;
            if (pos == FC + 1) m_rpc = m_target;
        end else begin
            pos = 0;
        end
    endtask

    task automatic check_outputs();
        chk("epc", epc, m_epc);
        chk("cause", {28'b0, cause}, {28'b0, m_cause});
        chk("status", {26'b0, status}, {26'b0, ie_o, 1'b0, ie_p, 1'b0, ie_c, 1'b0});
        chk("stall", {31'b0, stall}, {31'b0, (pos != 0)});
        chk("flush", {31'b0, flush}, {31'b0, (pos >= 1 && pos <= FC)});
        chk("pc_redirect", {31'b0, pc_redirect}, {31'b0, (pos == FC + 1)});
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("exc_taken", {31'b0, exc_taken}, {31'b0, m_taken});
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic clr_in();
        inst_valid = 1'b0; pc = '0; no_define = 1'b0; trap_sign = 1'b0;
        ovf = 1'b0; rfe = 1'b0; irq = 1'b0; sr_we = 1'b0; sr_wdata = '0;
    endtask

    typedef struct {
        logic [5:0]  pre;
        logic        iv;
        logic [31:0] pc;
        logic        irq, nd, ovf, trap;
        logic        taken;
        logic [3:0]  cause;
        logic [5:0]  st;
        logic [31:0] epc;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{6'b000010, 1'b1, 32'h400, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd10, 6'b001000, 32'h400};
        vt[1] = '{6'b000010, 1'b1, 32'h404, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  6'b001000, 32'h404};
        vt[2] = '{6'b101000, 1'b1, 32'h408, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd10, 6'b100000, 32'h408};
        vt[3] = '{6'b000000, 1'b1, 32'h40C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd12, 6'b000000, 32'h40C};
        vt[4] = '{6'b000010, 1'b1, 32'h410, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 6'b001000, 32'h410};
        vt[5] = '{6'b111111, 1'b0, 32'h414, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd13, 6'b101010, 32'h410};
        vt[6] = '{6'b101010, 1'b1, 32'h418, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  6'b101000, 32'h418};
        vt[7] = '{6'b000010, 1'b1, 32'h41C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  6'b000010, 32'h418};

        clr_in();
        model_reset();
        rst_n = 1'b0;
        #12;
        chk("rst_epc", epc, 32'h0);
        chk("rst_cause", {28'b0, cause}, 32'h0);
        chk("rst_status", {26'b0, status}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_flush", {31'b0, flush}, 32'h0);
        chk("rst_redirect", {31'b0, pc_redirect}, 32'h0);
        chk("rst_rpc", redirect_pc, 32'h0);
        chk("rst_taken", {31'b0, exc_taken}, 32'h0);
        rst_n = 1'b1;
        cycle();

        for (int i = 0; i < 8; i++) begin
            clr_in(); sr_we = 1'b1; sr_wdata = vt[i].pre;
            cycle();
            clr_in();
            inst_valid = vt[i].iv; pc = vt[i].pc; irq = vt[i].irq;
            no_define = vt[i].nd; ovf = vt[i].ovf; trap_sign = vt[i].trap;
            cycle();
            chk("vec_taken", {31'b0, exc_taken}, {31'b0, vt[i].taken});
            chk("vec_cause", {28'b0, cause}, {28'b0, vt[i].cause});
            chk("vec_status", {26'b0, status}, {26'b0, vt[i].st});
            chk("vec_epc", epc, vt[i].epc);
            clr_in();
            repeat (FC + 1) cycle();
        end

        // Exception then rfe back to EPC
        clr_in(); sr_we = 1'b1; sr_wdata = 6'b000010; cycle();
        clr_in(); inst_valid = 1'b1; pc = 32'h400; no_define = 1'b1; cycle();
        clr_in(); repeat (FC + 1) cycle();
        chk("pre_rfe_status", {26'b0, status}, 32'b001000);
        chk("pre_rfe_epc", epc, 32'h400);
        inst_valid = 1'b1; rfe = 1'b1; cycle();
        clr_in();
        chk("rfe_taken", {31'b0, exc_taken}, 32'h0);
        chk("rfe_status", {26'b0, status}, 32'b000010);
        for (int k = 0; k < FC; k++) begin
            chk("rfe_flush", {31'b0, flush}, 32'h1);
            chk("rfe_no_redirect", {31'b0, pc_redirect}, 32'h0);
            cycle();
        end
        chk("rfe_redirect", {31'b0, pc_redirect}, 32'h1);
        chk("rfe_rpc", redirect_pc, 32'h400);
        cycle();
        chk("rfe_idle", {31'b0, stall}, 32'h0);
        chk("rpc_hold", redirect_pc, 32'h400);

        // Events and status writes ignored while flushing
        inst_valid = 1'b1; pc = 32'h500; ovf = 1'b1; cycle();
        clr_in(); inst_valid = 1'b1; pc = 32'h600; trap_sign = 1'b1; rfe = 1'b1;
        sr_we = 1'b1; sr_wdata = 6'h3F;
        cycle();
        chk("mask_epc", epc, 32'h500);
        chk("mask_cause", {28'b0, cause}, 32'd12);
        chk("mask_status", {26'b0, status}, 32'b001000);
        clr_in(); repeat (FC) cycle();
        sr_we = 1'b1; sr_wdata = 6'h3F; cycle();
        clr_in();
        chk("sr_write", {26'b0, status}, 32'b101010);

        // Exception and rfe together: exception wins
        inst_valid = 1'b1; irq = 1'b1; rfe = 1'b1; pc = 32'h700; cycle();
        clr_in();
        chk("both_taken", {31'b0, exc_taken}, 32'h1);
        chk("both_cause", {28'b0, cause}, 32'd0);
        chk("both_status", {26'b0, status}, 32'b101000);
        chk("both_epc", epc, 32'h700);
        repeat (FC + 1) cycle();

        // Asynchronous reset in the middle of a flush
        inst_valid = 1'b1; no_define = 1'b1; pc = 32'h800; cycle();
        clr_in(); cycle();
        chk("pre_rst_flush", {31'b0, flush}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_flush", {31'b0, flush}, 32'h0);
        chk("mid_rst_stall", {31'b0, stall}, 32'h0);
        chk("mid_rst_epc", epc, 32'h0);
        chk("mid_rst_cause", {28'b0, cause}, 32'h0);
        chk("mid_rst_status", {26'b0, status}, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (FC + 2) cycle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            inst_valid = ($urandom_range(0, 3) != 0);
            pc         = $urandom & 32'hFFFF_FFFC;
            irq        = ($urandom_range(0, 5) == 0);
            no_define  = ($urandom_range(0, 9) == 0);
            ovf        = ($urandom_range(0, 9) == 0);
            trap_sign  = ($urandom_range(0, 9) == 0);
            rfe        = ($urandom_range(0, 7) == 0);
            sr_we      = ($urandom_range(0, 4) == 0);
            sr_wdata   = 6'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception sequencer for the single-issue core. Takes the decoder's undefined-instruction and trap flags, the ALU overflow flag, the decoded rfe and an external interrupt line.
- Maintains EPC, a cause code and a 3-level interrupt-enable stack.
- Sequences pipeline flush, then PC redirect to the exception vector, or back to EPC on rfe.

Parameters:
- PC_W, 32, width of PC and EPC
- VECTOR_ADDR, 32'h0000_0080, exception handler address
- FLUSH_CYCLES, 2, cycles flush is held before redirect (legal range 1..15)

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- inst_valid  in  1  current instruction is valid and in the commit stage
- pc  in  PC_W  PC of the current instruction
- no_define  in  1  decoder: undefined instruction
- trap_sign  in  1  decoder: trap instruction
- ovf  in  1  ALU signed overflow (add/sub/addi)
- rfe  in  1  decoder: rfe instruction
- irq  in  1  external interrupt, level, synchronous to clk
- sr_we  in  1  software write of status
- sr_wdata  in  6  status write data
- epc  out  PC_W  exception PC
- cause  out  4  exception cause code
- status  out  6  {IEo,KUo,IEp,KUp,IEc,KUc}; only IE bits are writable, KU bits read 0
- stall  out  1  hold fetch/decode
- flush  out  1  kill in-flight instructions
- pc_redirect  out  1  load redirect_pc into PC this cycle
- redirect_pc  out  PC_W  target PC
- exc_taken  out  1  one-cycle pulse on exception entry

Behaviour:
- Reset (async, rst_n=0): state IDLE; epc=0, cause=0, status=0, stall=0, flush=0, pc_redirect=0, redirect_pc=0, exc_taken=0, flush counter=0.
- States: IDLE, FLUSH, REDIRECT.
- IDLE, event evaluation: events are sampled only when inst_valid=1.
- Priority, highest first:
  - irq & status[1] (IEc): cause 0
  - no_define: cause 10
  - ovf: cause 12
  - trap_sign: cause 13
- Exception taken, at the edge:
  - epc<=pc, cause<=code
  - status<={status[3:0],2'b00} (push; IEc cleared)
  - exc_taken=1 for the next cycle
  - target<=VECTOR_ADDR, counter<=FLUSH_CYCLES-1, go to FLUSH
- rfe with no exception:
  - status<={status[5:4],status[5:2]} (pop)
  - target<=epc, counter<=FLUSH_CYCLES-1, go to FLUSH
  - exc_taken stays 0
- Exception and rfe in the same cycle: the exception wins and rfe is ignored.
- sr_we in IDLE with no exception or rfe: status<=sr_wdata & 6'b101010 (KU bits forced 0). sr_we is ignored when an exception or rfe fires in the same cycle, and in all other states.
- FLUSH: flush=1, stall=1. Counter decrements each cycle; at 0 go to REDIRECT. Flush is high for exactly FLUSH_CYCLES cycles.
- REDIRECT: pc_redirect=1, redirect_pc=target, stall=1, flush=0 for one cycle, then IDLE.
- redirect_pc holds its last value when pc_redirect=0.
- All event inputs are ignored in FLUSH and REDIRECT (no nesting; irq stays pending at the source).
- Latency: event edge to pc_redirect = FLUSH_CYCLES+1 cycles. Back-to-back exceptions are possible from the first IDLE cycle after REDIRECT.
- Outputs stall/flush/pc_redirect are registered-state decodes, glitch-free; epc/cause/status are registers.
- Reset mid-sequence: immediate return to IDLE with all reset values; any pending redirect is dropped.
- Status stack overflow: a third nested push discards the old IEo/KUo (shift-out). Pop copies IEo into both IEo and IEp.

Decomposition:
- Package exc_pkg: cause codes (CAUSE_INT=0, CAUSE_RI=10, CAUSE_OV=12, CAUSE_TR=13), state enum {IDLE,FLUSH,REDIRECT}, STATUS_WMASK=6'b101010.
- One sub-module, exc_prio_enc: combinational priority encoder. Inputs irq_en, no_define, ovf, trap_sign; outputs hit and 4-bit code.
- Counter width: $clog2(FLUSH_CYCLES+1).

Test Plan:
- Reset: hold rst_n=0 asynchronously mid-FLUSH -> all outputs 0, state IDLE on the next clock.
- Undefined instruction: inst_valid=1, pc=32'h0000_0400, no_define=1 -> exc_taken pulse; epc=0x400; cause=10; status 6'b000010->6'b001000; flush high 2 cycles; then pc_redirect=1 with redirect_pc=0x80 for 1 cycle.
- Priority: irq=1 with IEc=1, plus no_define=1, ovf=1, trap_sign=1 together -> cause=0. Repeat with IEc=0 -> cause=10; no_define=0, ovf=1 -> cause=12.
- rfe: after one exception, status=6'b001000, epc=0x400; rfe=1 -> status=6'b000010; redirect_pc=0x400 after 2 flush cycles; exc_taken stays 0.
- Masking: in FLUSH, apply trap_sign=1 and sr_we=1 with sr_wdata=6'h3F -> no change to epc/cause/status. In IDLE, sr_we with 6'h3F -> status=6'b101010.
- inst_valid gating: inst_valid=0 with no_define=1 and ovf=1 -> no exception, state remains IDLE.
